txt_render: RTL and testbench
=============================

// Module: txt_render
// PURPOSE
//  Parametrised text-mode renderer. Walks a character buffer held in main RAM,
//  looks up glyph rows in the character ROM and writes one 24-bit RGB pixel per
//  accepted cycle into the VRAM framebuffer that the VGA scanner reads.
//  Supports Apple II interleaved or linear buffer layouts, inverse and flash
//  attributes, programmable colours and back-pressure from the VRAM port.
// PARAMETERS
//  COLS         40       characters per text row
//  ROWS         24       text rows per frame
//  GLYPH_W      7        pixels per glyph row (crom_q[GLYPH_W-1:0] used)
//  GLYPH_H      8        scanlines per text row
//  TXT_BASE     16'h400  text buffer base address
//  INTERLEAVE   1        1: Apple II layout (requires COLS=40, ROWS=24); 0: linear
//  FLASH_FRAMES 16       frames per flash phase toggle
//  CONTINUOUS   0        1: restart a new frame automatically after frame_done
// PORTS
//  clk         in   1   pixel/system clock
//  res         in   1   reset, asynchronous, active-low
//  start       in   1   begin one frame; sampled only in IDLE
//  busy        out  1   high from the cycle after start until frame_done
//  frame_done  out  1   one-cycle pulse after the last pixel is accepted
//  txt_adr     out  16  character buffer address (main RAM)
//  txt_q       in   8   character code, valid 1 cycle after txt_adr
//  crom_adr    out  11  {code[7:0], glyph_row[2:0]}
//  crom_q      in   8   glyph row bits, valid 1 cycle after crom_adr
//  fg_rgb      in   24  foreground colour (lit glyph pixel, normal video)
//  bg_rgb      in   24  background colour
//  vram_wadr   out  16  framebuffer write address
//  vram_d      out  24  pixel data
//  vram_we     out  1   write request
//  vram_ready  in   1   write accepted when vram_we && vram_ready
// BEHAVIOUR
//  Clock/reset: one clock clk; res asynchronous, active-low.
//  Reset: state=IDLE.
//   Outputs: busy=0, frame_done=0, vram_we=0, vram_wadr=0, vram_d=0,
//   txt_adr=TXT_BASE, crom_adr=0.
//   Counters cleared; flash phase=0; flash frame count=0.
//  A reset mid-frame abandons the frame. There is no frame_done and no partial resume.
//  FSM:
//   IDLE -(start | CONTINUOUS)-> FETCH_CHR -> FETCH_GLY -> EMIT
//   EMIT -(last px of char accepted)-> FETCH_CHR, or DONE after the last char of the frame
//   DONE -> IDLE (frame_done=1 for this one cycle).
//  Scan order: scanline y=0..ROWS*GLYPH_H-1; col=0..COLS-1; px=0..GLYPH_W-1.
//   row = y / GLYPH_H; glyph_row = y % GLYPH_H.
//  FETCH_CHR: drive txt_adr; txt_q is captured on the following cycle.
//   INTERLEAVE=1: TXT_BASE + 128*(row%8) + 40*(row/8) + col.
//   INTERLEAVE=0: TXT_BASE + row*COLS + col.
//   Screen holes ($x78-$x7F) are never addressed.
//  FETCH_GLY: crom_adr={code, glyph_row[2:0]}; crom_q captured the next cycle, with attributes:
//   code[7:6]=00 inverse.
//   code[7:6]=01 flash (inverse when flash phase=1).
//   code[7]=1 normal.
//  EMIT: bit = glyph[GLYPH_W-1-px] (MSB-first); lit^invert ? fg_rgb : bg_rgb.
//   vram_we=1. px, vram_wadr and the pixel advance only on acceptance.
//   While vram_ready=0, vram_we, vram_wadr and vram_d hold stable.
//  vram_wadr = y*COLS*GLYPH_W + col*GLYPH_W + px. It is incremental with no multiplier.
//   It wraps to 0 at the start of each frame.
//  Throughput: GLYPH_W+2 cycles per character with no stalls.
//  start while busy: ignored. start held high in IDLE starts exactly one frame per IDLE visit.
//  Flash: frame counter increments at DONE; at FLASH_FRAMES it clears and toggles the phase.
//   The phase is constant within a frame.
// STRUCTURE
//  vdp_pkg:
//   typedef enum {IDLE, FETCH_CHR, FETCH_GLY, EMIT, DONE} txt_state_t.
//   Attribute decode function.
//   Function apple_row_base(row) returning 128*(row%8)+40*(row/8).
//  Sub-module txt_addr_gen:
//   Column/row/glyph-row counters and txt_adr generation.
//   Steps on a 'next_char' strobe from the FSM.
//  Top-level: FSM, glyph shift/select, colour mux, vram_wadr counter, flash counter.
// TESTING
//  1. Reset, start pulse, fg=FFFFFF, bg=000000, vram_ready=1:
//     - exactly 280*192 writes, last vram_wadr=53759.
//     - frame_done pulses once; busy falls the same cycle.
//  2. Interleave: txt_adr for (row,col) must be:
//     - (0,0)=$400, (1,0)=$480, (8,0)=$428, (16,0)=$450, (23,39)=$7F7.
//     - No address in $x78-$x7F.
//  3. Glyph: char $C1 with crom row0 = 8'b0_0010100:
//     - pixels 0..6 = bg,bg,fg,bg,fg,bg,bg.
//     - Same row with char $01 (inverse) gives the complement.
//  4. Flash, FLASH_FRAMES=2, char $41, CONTINUOUS=1: frames 0-1 normal, frames 2-3 inverse, frame 4 normal.
//  5. Back-pressure: vram_ready toggled randomly with 30% low:
//     - write sequence is identical to case 1.
//     - vram_we/wadr/d stay stable during stalls.
//  6. res low mid-EMIT: all outputs return to reset values asynchronously. The next start begins at vram_wadr=0, txt_adr=$400.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared types and helpers for the text-mode renderer.
package vdp_pkg;

    typedef enum logic [2:0] {IDLE, FETCH_CHR, FETCH_GLY, EMIT, DONE} txt_state_t;

    // Apple II attribute: 00 inverse, 01 flashing, 1x normal.
    function automatic logic attr_invert(input logic [7:0] code, input logic flash_phase);
        if (code[7])
            return 1'b0;
        else if (code[6])
            return flash_phase;
        else
            return 1'b1;
    endfunction

    function automatic logic [15:0] apple_row_base(input logic [4:0] row);
        logic [15:0] r8;
        r8 = {14'd0, row[4:3]};
        return {6'd0, row[2:0], 7'd0} + (r8 << 5) + (r8 << 3);
    endfunction

endpackage

// File: rtl/txt_addr_gen.sv
// Column / text-row / glyph-row counters and character buffer address.
module txt_addr_gen
    import vdp_pkg::*;
#(
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 24,
    parameter int unsigned GLYPH_H    = 8,
    parameter logic [15:0] TXT_BASE   = 16'h0400,
    parameter bit          INTERLEAVE = 1'b1
) (
    input  logic        clk,
    input  logic        res,
    input  logic        clear,
    input  logic        next_char,
    output logic [15:0] txt_adr,
    output logic [2:0]  glyph_row,
    output logic        last_char
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned GW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [GW-1:0] GY_LAST  = GW'(GLYPH_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [GW-1:0] gy;
    logic [15:0]   row_base;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            col <= '0;
            row <= '0;
            gy  <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
            gy  <= '0;
        end else if (next_char) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (gy == GY_LAST) begin
                    gy  <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    gy <= gy + GW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_comb begin
        if (INTERLEAVE)
            row_base = apple_row_base(5'(row));
        else
            row_base = 16'(row * COLS);
        txt_adr   = TXT_BASE + row_base + 16'(col);
        glyph_row = 3'(gy);
        last_char = (col == COL_LAST) && (gy == GY_LAST) && (row == ROW_LAST);
    end

endmodule

// File: rtl/txt_render.sv
// Text-mode renderer: character buffer -> glyph ROM -> RGB pixels into VRAM.
module txt_render
    import vdp_pkg::*;
#(
    parameter int unsigned COLS         = 40,
    parameter int unsigned ROWS         = 24,
    parameter int unsigned GLYPH_W      = 7,
    parameter int unsigned GLYPH_H      = 8,
    parameter logic [15:0] TXT_BASE     = 16'h0400,
    parameter bit          INTERLEAVE   = 1'b1,
    parameter int unsigned FLASH_FRAMES = 16,
    parameter bit          CONTINUOUS   = 1'b0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] txt_adr,
    input  logic [7:0]  txt_q,
    output logic [10:0] crom_adr,
    input  logic [7:0]  crom_q,
    input  logic [23:0] fg_rgb,
    input  logic [23:0] bg_rgb,
    output logic [15:0] vram_wadr,
    output logic [23:0] vram_d,
    output logic        vram_we,
    input  logic        vram_ready
);

    localparam int unsigned PW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [PW-1:0] PX_LAST = PW'(GLYPH_W - 1);
    localparam logic [FW-1:0] FL_LAST = FW'(FLASH_FRAMES - 1);

    txt_state_t    state, state_nx;
    logic [PW-1:0] px;
    logic [7:0]    code;
    logic [15:0]   wadr;
    logic [FW-1:0] fcnt;
    logic          phase;
    logic          frame_start, accept, next_char, last_char, pix_lit;
    logic [2:0]    glyph_row, bit_idx;

    assign frame_start = (state == IDLE) && (start || CONTINUOUS);
    assign accept      = (state == EMIT) && vram_ready;
    assign next_char   = accept && (px == PX_LAST);
    assign bit_idx     = 3'(PX_LAST - px);
    assign pix_lit     = crom_q[bit_idx] ^ attr_invert(code, phase);
    assign vram_wadr   = wadr;

    txt_addr_gen #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .GLYPH_H    (GLYPH_H),
        .TXT_BASE   (TXT_BASE),
        .INTERLEAVE (INTERLEAVE)
    ) u_addr (
        .clk       (clk),
        .res       (res),
        .clear     (frame_start),
        .next_char (next_char),
        .txt_adr   (txt_adr),
        .glyph_row (glyph_row),
        .last_char (last_char)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start || CONTINUOUS) state_nx = FETCH_CHR;
            FETCH_CHR: state_nx = FETCH_GLY;
            FETCH_GLY: state_nx = EMIT;
            EMIT:      if (next_char) state_nx = last_char ? DONE : FETCH_CHR;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // crom_adr follows txt_q directly in FETCH_GLY and is then held from the
    // captured code, so crom_q stays valid for every pixel of the character.
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        vram_we    = 1'b0;
        vram_d     = '0;
        crom_adr   = {code, glyph_row};
        case (state)
            FETCH_CHR: busy = 1'b1;
            FETCH_GLY: begin
                busy     = 1'b1;
                crom_adr = {txt_q, glyph_row};
            end
            EMIT: begin
                busy    = 1'b1;
                vram_we = 1'b1;
                vram_d  = pix_lit ? fg_rgb : bg_rgb;
            end
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            px    <= '0;
            code  <= '0;
            wadr  <= '0;
            fcnt  <= '0;
            phase <= 1'b0;
        end else begin
            if (state == FETCH_GLY)
                code <= txt_q;
            if (frame_start)
                wadr <= '0;
            else if (accept)
                wadr <= wadr + 16'd1;
            if (next_char)
                px <= '0;
            else if (accept)
                px <= px + PW'(1);
            if (state == DONE) begin
                if (fcnt == FL_LAST) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_txt_render.sv
// Directed bench for txt_render: full frames, interleave, glyphs, flash, stalls, reset.
module tb_txt_render;

    localparam int unsigned GH   = 2;
    localparam int unsigned NCHR = 40 * 24 * GH;
    localparam int unsigned NPIX = NCHR * 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res = 1'b1, res_f = 1'b1, start = 1'b0, vram_ready = 1'b1;
    logic        bp_en = 1'b0, mon_clr = 1'b0;
    logic [23:0] fg = 24'hFFFFFF, bg = 24'h000000;

    logic        busy, frame_done, vram_we;
    logic [15:0] txt_adr, vram_wadr;
    logic [7:0]  txt_q, crom_q;
    logic [10:0] crom_adr;
    logic [23:0] vram_d;

    logic        busy_f, frame_done_f, vram_we_f;
    logic [15:0] txt_adr_f, vram_wadr_f;
    logic [7:0]  txt_q_f, crom_q_f;
    logic [10:0] crom_adr_f;
    logic [23:0] vram_d_f;

    txt_render #(
        .COLS(40), .ROWS(24), .GLYPH_W(7), .GLYPH_H(GH), .TXT_BASE(16'h0400),
        .INTERLEAVE(1'b1), .FLASH_FRAMES(16), .CONTINUOUS(1'b0)
    ) dut (
        .clk(clk), .res(res), .start(start), .busy(busy), .frame_done(frame_done),
        .txt_adr(txt_adr), .txt_q(txt_q), .crom_adr(crom_adr), .crom_q(crom_q),
        .fg_rgb(fg), .bg_rgb(bg), .vram_wadr(vram_wadr), .vram_d(vram_d),
        .vram_we(vram_we), .vram_ready(vram_ready)
    );

    txt_render #(
        .COLS(2), .ROWS(1), .GLYPH_W(7), .GLYPH_H(1), .TXT_BASE(16'h0800),
        .INTERLEAVE(1'b0), .FLASH_FRAMES(2), .CONTINUOUS(1'b1)
    ) dut_f (
        .clk(clk), .res(res_f), .start(1'b0), .busy(busy_f), .frame_done(frame_done_f),
        .txt_adr(txt_adr_f), .txt_q(txt_q_f), .crom_adr(crom_adr_f), .crom_q(crom_q_f),
        .fg_rgb(24'hF0F0F0), .bg_rgb(24'h0F0F0F), .vram_wadr(vram_wadr_f), .vram_d(vram_d_f),
        .vram_we(vram_we_f), .vram_ready(1'b1)
    );

    function automatic logic [7:0] ram(input logic [15:0] a);
        case (a)
            16'h0400: return 8'hC1;
            16'h0401: return 8'h01;
            16'h0402: return 8'h82;
            16'h0403: return 8'h41;
            default:  return a[7:0] ^ {a[10:8], 5'b01101};
        endcase
    endfunction

    function automatic logic [7:0] rom(input logic [10:0] a);
        if (a[2:0] == 3'd0 && (a[10:3] == 8'hC1 || a[10:3] == 8'h01 || a[10:3] == 8'h41))
            return 8'h14;
        if (a == {8'h82, 3'd0})
            return 8'hC1;
        return a[7:0] ^ {a[2:0], a[10:6]};
    endfunction

    always @(posedge clk) begin
        txt_q    <= ram(txt_adr);
        crom_q   <= rom(crom_adr);
        txt_q_f  <= 8'h41;
        crom_q_f <= rom(crom_adr_f);
    end

    always @(posedge clk) begin
        #1;
        vram_ready = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    function automatic logic [15:0] m_txt_adr(input int unsigned row, input int unsigned col);
        return 16'(32'h400 + 128 * (row % 8) + 40 * (row / 8) + col);
    endfunction

    // Main instance never reaches 16 frames, so flash phase is 0 here.
    function automatic logic [23:0] m_pix(input int unsigned k, input logic [23:0] f, input logic [23:0] b);
        int unsigned chi = k / 7;
        int unsigned px  = k % 7;
        int unsigned y   = chi / 40;
        logic [7:0]  code = ram(m_txt_adr(y / GH, chi % 40));
        logic [7:0]  g    = rom({code, 3'(y % GH)});
        logic        inv  = code[7] ? 1'b0 : (code[6] ? 1'b0 : 1'b1);
        return (g[6 - px] ^ inv) ? f : b;
    endfunction

    logic [15:0] wr_a [NPIX];
    logic [23:0] wr_d [NPIX];
    logic [15:0] addr_seen [24][40];
    int unsigned wr_n, fd_n, bz_err, st_err, st_n, holes;
    logic        prev_st = 1'b0, prev_busy = 1'b0;
    logic [15:0] st_a;
    logic [23:0] st_d;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_n = 0; fd_n = 0; bz_err = 0; st_err = 0; st_n = 0; holes = 0; prev_st = 1'b0;
        end else begin
            if (prev_st && !(vram_we && vram_wadr == st_a && vram_d == st_d))
                st_err++;
            prev_st = vram_we && !vram_ready;
            st_a    = vram_wadr;
            st_d    = vram_d;
            if (prev_st)
                st_n++;
            if (frame_done) begin
                fd_n++;
                if (busy || !prev_busy)
                    bz_err++;
            end
            prev_busy = busy;
            if (vram_we && vram_ready) begin
                if (wr_n < NPIX) begin
                    wr_a[wr_n] = vram_wadr;
                    wr_d[wr_n] = vram_d;
                    if (wr_n % 7 == 0 && (wr_n / 280) % GH == 0)
                        addr_seen[(wr_n / 280) / GH][(wr_n / 7) % 40] = txt_adr;
                end
                if (txt_adr[6:0] >= 7'h78)
                    holes++;
                wr_n++;
            end
        end
    end

    logic [13:0] f_bits [8];
    int unsigned f_frame, f_k, f_wad_err;

    always @(negedge clk) begin
        if (!res_f) begin
            f_frame = 0; f_k = 0; f_wad_err = 0;
        end else begin
            if (vram_we_f) begin
                if (f_frame < 8 && f_k < 14)
                    f_bits[f_frame][13 - f_k] = (vram_d_f == 24'hF0F0F0);
                if (vram_wadr_f != 16'(f_k))
                    f_wad_err++;
                f_k++;
            end
            if (frame_done_f) begin
                f_frame++;
                f_k = 0;
            end
        end
    end

    int unsigned n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned c = 0;
        while (fd_n < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (fd_n < n)
            chk({tag, " timeout"}, fd_n, n);
    endtask

    task automatic wait_writes(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned c = 0;
        while (wr_n < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (wr_n < n)
            chk({tag, " timeout"}, wr_n, n);
    endtask

    task automatic verify_frame(input string tag);
        int unsigned bad = 0;
        int unsigned first = 0;
        for (int unsigned k = 0; k < NPIX; k++) begin
            if (wr_a[k] !== 16'(k) || wr_d[k] !== m_pix(k, fg, bg)) begin
                if (bad == 0)
                    first = k;
                bad++;
            end
        end
        chk({tag, " write count"}, wr_n, NPIX);
        chk({tag, " last wadr"}, wr_a[NPIX - 1], NPIX - 1);
        chk($sformatf("%s pixel seq bad (first k=%0d)", tag, first), bad, 0);
        chk({tag, " frame_done count"}, fd_n, 1);
        chk({tag, " busy vs frame_done"}, bz_err, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        chk({tag, " vram_we"}, vram_we, 0);
        chk({tag, " vram_wadr"}, vram_wadr, 0);
        chk({tag, " vram_d"}, vram_d, 0);
        chk({tag, " txt_adr"}, txt_adr, 16'h0400);
        chk({tag, " crom_adr"}, crom_adr, 0);
    endtask

    typedef struct { int unsigned row; int unsigned col; logic [15:0] adr; } adr_vec_t;
    typedef struct { int unsigned base; logic [6:0] pat; } gly_vec_t;
    typedef struct { int unsigned frame; logic [13:0] pat; } fl_vec_t;

    adr_vec_t av [8];
    gly_vec_t gv [4];
    fl_vec_t  fv [5];

    initial begin
        av[0] = '{0, 0, 16'h0400};   av[1] = '{1, 0, 16'h0480};
        av[2] = '{8, 0, 16'h0428};   av[3] = '{16, 0, 16'h0450};
        av[4] = '{23, 39, 16'h07F7}; av[5] = '{7, 39, 16'h07A7};
        av[6] = '{15, 0, 16'h07A8};  av[7] = '{2, 5, 16'h0505};
        gv[0] = '{0, 7'b0010100};    gv[1] = '{7, 7'b1101011};
        gv[2] = '{14, 7'b1000001};   gv[3] = '{21, 7'b0010100};
        fv[0] = '{0, 14'b0010100_0010100}; fv[1] = '{1, 14'b0010100_0010100};
        fv[2] = '{2, 14'b1101011_1101011}; fv[3] = '{3, 14'b1101011_1101011};
        fv[4] = '{4, 14'b0010100_0010100};

        #3 res = 1'b0;
        res_f = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 res = 1'b1;
        clear_mon();

        // Frame 1, with a start pulse mid-frame that must be ignored.
        pulse_start();
        @(negedge clk);
        chk("busy after start", busy, 1);
        repeat (100) @(negedge clk);
        pulse_start();
        wait_frames(1, 20000, "frame1");
        repeat (30) @(negedge clk);
        chk("no second frame", fd_n, 1);
        chk("idle after frame", busy, 0);
        verify_frame("frame1");
        foreach (av[i])
            chk($sformatf("txt_adr r%0d c%0d", av[i].row, av[i].col),
                addr_seen[av[i].row][av[i].col], av[i].adr);
        chk("screen hole addressed", holes, 0);
        foreach (gv[i]) begin
            logic [6:0] got;
            for (int unsigned p = 0; p < 7; p++)
                got[6 - p] = (wr_d[gv[i].base + p] == fg);
            chk($sformatf("glyph at %0d", gv[i].base), got, gv[i].pat);
        end

        // Same frame under random back-pressure.
        clear_mon();
        bp_en = 1'b1;
        pulse_start();
        wait_frames(1, 40000, "bp");
        bp_en = 1'b0;
        repeat (5) @(negedge clk);
        verify_frame("bp");
        chk("stall hold", st_err, 0);
        chk("stalls seen", st_n > 0, 1);

        // Reset in the middle of EMIT abandons the frame.
        clear_mon();
        pulse_start();
        wait_writes(50, 2000, "pre-reset");
        @(negedge clk);
        #2 res = 1'b0;
        #1 check_reset_outputs("async reset");
        repeat (4) @(negedge clk);
        chk("no frame_done on abort", fd_n, 0);
        @(posedge clk);
        #1 res = 1'b1;
        clear_mon();
        pulse_start();
        wait_writes(20, 500, "restart");
        chk("restart first wadr", wr_a[0], 0);
        chk("restart first txt_adr", addr_seen[0][0], 16'h0400);
        for (int unsigned k = 0; k < 20; k++)
            chk($sformatf("restart pixel %0d", k), {wr_a[k], wr_d[k]}, {16'(k), m_pix(k, fg, bg)});
        res = 1'b0;

        // Flash instance: continuous frames, phase toggles every 2 frames.
        @(posedge clk);
        #1 res_f = 1'b1;
        for (int unsigned c = 0; c < 1000 && f_frame < 5; c++)
            @(negedge clk);
        chk("flash frames reached", f_frame >= 5, 1);
        res_f = 1'b0;
        foreach (fv[i])
            chk($sformatf("flash frame %0d", fv[i].frame), f_bits[fv[i].frame], fv[i].pat);
        chk("flash wadr seq", f_wad_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
